// File: rtl/fpga_status_pkg.sv
// Shared types and timing constants for the FPGA status LED controller.
//   led_mode_e   : per-channel LED mode
//   exit_state_e : exit-code serialiser states
//   *_TICKS      : serialiser state durations in prescaler ticks
package fpga_status_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_EXIT  = 2'd3
  } led_mode_e;

  typedef enum logic [2:0] {
    EXIT_IDLE    = 3'd0,
    EXIT_START   = 3'd1,
    EXIT_SEP     = 3'd2,
    EXIT_BIT_ON  = 3'd3,
    EXIT_BIT_OFF = 3'd4,
    EXIT_PAUSE   = 3'd5
  } exit_state_e;

  localparam int unsigned START_TICKS = 4;
  localparam int unsigned SEP_TICKS   = 2;
  localparam int unsigned ONE_TICKS   = 3;
  localparam int unsigned ZERO_TICKS  = 1;
  localparam int unsigned OFF_TICKS   = 2;
  localparam int unsigned PAUSE_TICKS = 8;

  // Duration counter width; must hold the longest duration minus one.
  localparam int unsigned DUR_W = 4;

  // Counter load value for a state lasting 'ticks' ticks.
  function automatic logic [DUR_W-1:0] dur_load(input int unsigned ticks);
    return DUR_W'(ticks - 1);
  endfunction

endpackage

// File: rtl/fpga_status_exit_serializer.sv
// Captures the program exit value on the first valid rising edge and
// repeatedly serialises its low EXIT_BITS bits as long/short pulses.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_tick         : prescaler tick, one cycle wide
//   i_valid        : exit valid (level or pulse)
//   i_value        : exit value bits to display
//   o_serial_c     : serial output, decoded from the current state
//   o_busy         : high while the FSM is out of IDLE
module fpga_status_exit_serializer
  import fpga_status_pkg::*;
#(
  parameter int unsigned EXIT_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick,
  input  logic                 i_valid,
  input  logic [EXIT_BITS-1:0] i_value,
  output logic                 o_serial_c,
  output logic                 o_busy
);

  localparam int unsigned IDX_W = (EXIT_BITS > 1) ? $clog2(EXIT_BITS) : 1;

  exit_state_e          r_state;
  exit_state_e          w_state_nxt;
  logic [DUR_W-1:0]     r_dur;
  logic [DUR_W-1:0]     w_dur_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [IDX_W-1:0]     w_idx_dec;
  logic [EXIT_BITS-1:0] r_value;
  logic                 r_valid_q;
  logic                 r_busy;
  logic                 w_edge;
  logic                 w_capture;

  // Reset clears r_valid_q, so a level already high at release reads as an edge.
  assign w_edge    = i_valid & ~r_valid_q;
  assign w_idx_dec = r_idx - IDX_W'(1);

  function automatic logic [DUR_W-1:0] bit_dur(input logic b);
    return b ? dur_load(ONE_TICKS) : dur_load(ZERO_TICKS);
  endfunction

  // Next-state logic: duration counter counts down on ticks, state moves at zero.
  always_comb begin
    w_state_nxt = r_state;
    w_dur_nxt   = r_dur;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    if (r_state == EXIT_IDLE) begin
      // A coincident tick is deliberately not applied to the fresh START count.
      if (w_edge) begin
        w_capture   = 1'b1;
        w_state_nxt = EXIT_START;
        w_dur_nxt   = dur_load(START_TICKS);
      end
    end else if (i_tick) begin
      if (r_dur != '0) begin
        w_dur_nxt = r_dur - DUR_W'(1);
      end else begin
        case (r_state)
          EXIT_START: begin
            w_state_nxt = EXIT_SEP;
            w_dur_nxt   = dur_load(SEP_TICKS);
          end
          EXIT_SEP: begin
            w_state_nxt = EXIT_BIT_ON;
            w_idx_nxt   = IDX_W'(EXIT_BITS - 1);
            w_dur_nxt   = bit_dur(r_value[EXIT_BITS-1]);
          end
          EXIT_BIT_ON: begin
            w_state_nxt = EXIT_BIT_OFF;
            w_dur_nxt   = dur_load(OFF_TICKS);
          end
          EXIT_BIT_OFF: begin
            if (r_idx != '0) begin
              w_state_nxt = EXIT_BIT_ON;
              w_idx_nxt   = w_idx_dec;
              w_dur_nxt   = bit_dur(r_value[w_idx_dec]);
            end else begin
              w_state_nxt = EXIT_PAUSE;
              w_dur_nxt   = dur_load(PAUSE_TICKS);
            end
          end
          EXIT_PAUSE: begin
            w_state_nxt = EXIT_START;
            w_dur_nxt   = dur_load(START_TICKS);
          end
          default: begin
            w_state_nxt = EXIT_IDLE;
          end
        endcase
      end
    end
  end

  // State, counters, edge register and latched value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= EXIT_IDLE;
      r_dur     <= '0;
      r_idx     <= '0;
      r_value   <= '0;
      r_valid_q <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dur     <= w_dur_nxt;
      r_idx     <= w_idx_nxt;
      r_valid_q <= i_valid;
      r_busy    <= (w_state_nxt != EXIT_IDLE);
      if (w_capture) begin
        r_value <= i_value;
      end
    end
  end

  assign o_serial_c = (r_state == EXIT_START) || (r_state == EXIT_BIT_ON);
  assign o_busy     = r_busy;

endmodule

// File: rtl/fpga_status_led_ctrl.sv
// Board-visibility controller: NUM_LEDS independently moded LED channels
// (off / on / shared blink / exit-code display) driven from a tick prescaler.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   mode_i        : per-channel mode, channel k at [2k+1:2k]
//   blink_half_i  : blink half-period minus one, in ticks
//   exit_valid_i  : program exit valid
//   exit_value_i  : program exit value
//   led_o         : registered LED drive, active-high
//   tick_o        : one-cycle tick pulse
//   exit_busy_o   : exit serialiser is out of IDLE
module fpga_status_led_ctrl
  import fpga_status_pkg::*;
#(
  parameter int unsigned NUM_LEDS       = 4,
  parameter int unsigned TICK_DIV_WIDTH = 22,
  parameter int unsigned EXIT_BITS      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [2*NUM_LEDS-1:0] mode_i,
  input  logic [3:0]            blink_half_i,
  input  logic                  exit_valid_i,
  input  logic [31:0]           exit_value_i,
  output logic [NUM_LEDS-1:0]   led_o,
  output logic                  tick_o,
  output logic                  exit_busy_o
);

  localparam logic [TICK_DIV_WIDTH-1:0] PRESC_LAST = '1;
  localparam logic [TICK_DIV_WIDTH-1:0] PRESC_PRE  = PRESC_LAST - TICK_DIV_WIDTH'(1);

  logic [TICK_DIV_WIDTH-1:0] r_presc;
  logic                      r_tick;
  logic [3:0]                r_bcnt;
  logic                      r_phase;
  logic [NUM_LEDS-1:0]       r_led;
  logic [NUM_LEDS-1:0]       w_led_nxt;
  logic                      w_serial;
  logic                      w_busy;

  // Prescaler; r_tick is registered one count early so it is high exactly
  // while the counter is all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= r_presc + TICK_DIV_WIDTH'(1);
      r_tick  <= (r_presc == PRESC_PRE);
    end
  end

  // Shared blink generator; >= keeps it running when the half-period shrinks.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (r_tick) begin
      if (r_bcnt >= blink_half_i) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + 4'd1;
      end
    end
  end

  fpga_status_exit_serializer #(
    .EXIT_BITS (EXIT_BITS)
  ) u_exit_ser (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_tick     (r_tick),
    .i_valid    (exit_valid_i),
    .i_value    (exit_value_i[EXIT_BITS-1:0]),
    .o_serial_c (w_serial),
    .o_busy     (w_busy)
  );

  // Bits above the displayed width are intentionally ignored.
  if (EXIT_BITS < 32) begin : g_unused_hi
    logic w_unused_value_hi;
    assign w_unused_value_hi = ^exit_value_i[31:EXIT_BITS];
  end

  // Per-channel source select.
  always_comb begin
    w_led_nxt = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      case (led_mode_e'(mode_i[2*k +: 2]))
        LED_OFF:   w_led_nxt[k] = 1'b0;
        LED_ON:    w_led_nxt[k] = 1'b1;
        LED_BLINK: w_led_nxt[k] = r_phase;
        LED_EXIT:  w_led_nxt[k] = w_serial;
        default:   w_led_nxt[k] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_nxt;
    end
  end

  assign led_o       = r_led;
  assign tick_o      = r_tick;
  assign exit_busy_o = w_busy;

endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// Scoreboard bench for fpga_status_led_ctrl (4 LEDs, tick every 8 cycles, 4 exit bits).
module tb_fpga_status_led_ctrl;

  localparam int unsigned NL  = 4;
  localparam int unsigned TDW = 3;
  localparam int unsigned EB  = 4;
  localparam int          TP  = 1 << TDW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2*NL-1:0] mode;
  logic [3:0]    half;
  logic          valid;
  logic [31:0]   value;
  logic [NL-1:0] led;
  logic          tick;
  logic          busy;

  always #5 clk = ~clk;

  fpga_status_led_ctrl #(
    .NUM_LEDS       (NL),
    .TICK_DIV_WIDTH (TDW),
    .EXIT_BITS      (EB)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mode_i       (mode),
    .blink_half_i (half),
    .exit_valid_i (valid),
    .exit_value_i (value),
    .led_o        (led),
    .tick_o       (tick),
    .exit_busy_o  (busy)
  );

  typedef struct packed {
    logic [NL-1:0] led;
    logic          tick;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state, in cycle/tick terms.
  int m_n;            // clock edges since reset release
  bit m_phase;        // blink phase
  int m_bticks;       // ticks since last blink toggle
  bit m_prev_valid;
  bit m_active;       // display running
  int m_k;            // ticks since capture (tick in capture cycle excluded)
  bit m_pat[$];       // one entry per tick of the display pattern

  // Pattern as a list of per-tick levels, straight from the pulse rules.
  function automatic void build_pattern(input logic [31:0] v);
    m_pat.delete();
    repeat (4) m_pat.push_back(1'b1);
    repeat (2) m_pat.push_back(1'b0);
    for (int i = EB - 1; i >= 0; i--) begin
      repeat (v[i] ? 3 : 1) m_pat.push_back(1'b1);
      repeat (2) m_pat.push_back(1'b0);
    end
    repeat (8) m_pat.push_back(1'b0);
  endfunction

  // Advance the model by one clock edge and queue the outputs expected after it.
  task automatic step();
    exp_t e;
    bit   cur_tick;
    bit   ser;
    @(posedge clk);
    e = '0;
    if (!rst_n) begin
      m_n = 0; m_phase = 1'b0; m_bticks = 0;
      m_prev_valid = 1'b0; m_active = 1'b0; m_k = 0;
    end else begin
      cur_tick = ((m_n % TP) == TP - 1);
      ser = m_active ? m_pat[m_k % m_pat.size()] : 1'b0;
      for (int c = 0; c < NL; c++) begin
        case (mode[2*c +: 2])
          2'd0: e.led[c] = 1'b0;
          2'd1: e.led[c] = 1'b1;
          2'd2: e.led[c] = m_phase;
          default: e.led[c] = ser;
        endcase
      end
      if (cur_tick) begin
        if (m_bticks >= int'(half)) begin
          m_phase = ~m_phase;
          m_bticks = 0;
        end else begin
          m_bticks++;
        end
      end
      if (m_active) begin
        if (cur_tick) m_k++;
      end else if (valid && !m_prev_valid) begin
        m_active = 1'b1;
        m_k = 0;
        build_pattern(value);
      end
      m_prev_valid = valid;
      m_n++;
      e.tick = ((m_n % TP) == TP - 1);
      e.busy = m_active;
    end
    exp_q.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compares each queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (led !== e.led) begin
          errors++;
          $display("FAIL led t=%0t got=%b exp=%b", $time, led, e.led);
        end
        checks++;
        if (tick !== e.tick) begin
          errors++;
          $display("FAIL tick t=%0t got=%b exp=%b", $time, tick, e.tick);
        end
        checks++;
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, e.busy);
        end
      end
    end
  end

  initial begin
    bit found;
    rst_n = 1'b0; mode = 8'hFF; half = 4'd1; valid = 1'b0; value = '0;

    // Reset hold with random inputs
    for (int i = 0; i < 6; i++) begin
      half = 4'($urandom); valid = 1'($urandom); value = $urandom;
      step();
    end
    mode = '0; half = 4'd1; valid = 1'b0; rst_n = 1'b1;
    run(26);

    // Static modes
    mode = 8'b00_01_00_01; run(5);
    mode = 8'h00; run(3);

    // Blink, then shrink half-period mid-phase
    mode = 8'h02; half = 4'd1; run(44);
    half = 4'd0; run(40);

    // Exit display of 0xA, with an ignored second pulse of 5
    mode = 8'b00_11_00_10; value = 32'h0000_000A; valid = 1'b1; step();
    valid = 1'b0; run(260);
    value = 32'h5; valid = 1'b1; run(3);
    valid = 1'b0; run(250);

    // Randomised phase
    for (int i = 0; i < 300; i++) begin
      if ((i % 16) == 0) begin
        mode = 8'($urandom);
        half = 4'($urandom_range(0, 3));
      end
      valid = ($urandom_range(0, 15) == 0);
      value = $urandom;
      step();
    end

    // Reset in the middle of the first BIT_ON, then display 3
    rst_n = 1'b0; valid = 1'b0; step();
    rst_n = 1'b1; mode = 8'b00_11_00_00; run(2);
    value = 32'hA; valid = 1'b1; step(); valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_active && m_k >= 6 && m_pat[m_k % m_pat.size()]) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL bit_on_wait got=timeout exp=reached");
    end
    rst_n = 1'b0; step();
    rst_n = 1'b1; run(3);
    value = 32'h3; valid = 1'b1; step(); valid = 1'b0;
    run(260);

    // Capture edge coincident with a tick
    rst_n = 1'b0; step();
    rst_n = 1'b1; mode = 8'hFF;
    for (int i = 0; i < 20 && (m_n % TP) != TP - 1; i++) step();
    value = $urandom; valid = 1'b1; step(); valid = 1'b0;
    run(80);

    // Valid level-high across reset release
    rst_n = 1'b0; valid = 1'b1; value = 32'h9; run(2);
    rst_n = 1'b1; run(60);
    valid = 1'b0; run(10);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
